imem_boot_loader: RTL and testbench

- Sits directly upstream of the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core in reset until the whole program is loaded, then releases it. Malformed images are reported and the core stays in reset.

---
 rtl/imem_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream into 32-bit little-endian words, writes them to imem,
// and releases core_rst once the image is loaded. Define IMEM_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_boot_loader #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    localparam int IW = $clog2(MEM_WORDS) + 1;

    // Handshake: a byte transfers on a rising clk edge where byte_valid and byte_ready are
    // both high; byte_data is ignored otherwise, and byte_valid may drop on any cycle.
    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_HCHK  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    byte_cnt;
    logic [31:0]   hdr;
    logic [23:0]   word_sr;
    logic [IW-1:0] idx;
    logic          accept;
    logic          last_word;
    logic          hdr_bad;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign accept    = byte_valid & byte_ready;
    assign last_word = ((32'(idx) + 32'd1) == hdr);
    assign hdr_bad   = (hdr == 32'd0) || (hdr > 32'(MEM_WORDS));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HDR;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_HDR: begin
                if (accept && byte_cnt == 2'd3) begin
                    state_nx = ST_HCHK;
                end
            end
            ST_HCHK: begin
                state_nx = hdr_bad ? ST_ERR : ST_LOAD;
            end
            ST_LOAD: begin
                if (accept && byte_cnt == 2'd3) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_word) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    state_nx = ST_CSUM;
`else
                    state_nx = ST_DONE;
`endif
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            ST_CSUM: begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_nx = (byte_data == csum) ? ST_DONE : ST_ERR;
                end
`else
                state_nx = ST_ERR;
`endif
            end
            ST_DONE: state_nx = ST_DONE;
            ST_ERR:  state_nx = ST_ERR;
            default: state_nx = ST_ERR;
        endcase
    end

    // Outputs decode straight from state so core_rst rises the instant rst asserts.
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        core_rst   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_HDR, ST_LOAD, ST_CSUM: byte_ready = 1'b1;
            ST_WRITE:                 imem_we    = 1'b1;
            ST_DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ST_ERR:                   error      = 1'b1;
            default: ;
        endcase
    end

    // Byte counter and header/word assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            hdr      <= 32'd0;
            word_sr  <= 24'd0;
        end else if (accept && (state == ST_HDR || state == ST_LOAD)) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ST_HDR) begin
                hdr <= {byte_data, hdr[31:8]};
            end else begin
                word_sr <= {byte_data, word_sr[23:8]};
            end
        end
    end

    // Write port registers are loaded on the 4th byte so they are valid in WRITE and hold after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr <= BASE_ADDR;
            imem_wd   <= 32'd0;
            idx       <= '0;
        end else begin
            if (state == ST_LOAD && accept && byte_cnt == 2'd3) begin
                imem_wd   <= {byte_data, word_sr};
                imem_addr <= BASE_ADDR + (32'(idx) << 2);
            end
            if (state == ST_WRITE) begin
                idx <= idx + IW'(1);
            end
        end
    end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only; the header never contributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (state == ST_LOAD && accept) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares every imem_we pulse.
module tb_imem_boot_loader;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_rst;
    logic        done;
    logic        error;

    logic [63:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          n_writes;
    logic [7:0]  xsum;

    imem_boot_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wd(imem_wd), .core_rst(core_rst), .done(done), .error(error)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            logic [63:0] e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e[63:32]);
                check("write_data", imem_wd, e[31:0]);
            end
        end
    end

    // Drivers
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        byte_valid = 1'b0;
        xsum = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: byte_ready 0 after %0d cycles, required 1", n);
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            xsum = xsum ^ w[8*i +: 8];
            if (gap > 0 && (i % 2) == 0) idle(gap);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!done && !error && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done && !error) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: done/error still 0 after %0d cycles, required one set", name, n);
        end
    endtask

    task automatic check_ok(input string name, input int wr_before, input int wr_exp);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_core_rst"}, 32'(core_rst), 32'd0);
        check({name, "_writes"}, 32'(n_writes - wr_before), 32'(wr_exp));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string name, input int wr_before, input int wr_exp);
        check({name, "_error"}, 32'(error), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_core_rst"}, 32'(core_rst), 32'd1);
        check({name, "_writes"}, 32'(n_writes - wr_before), 32'(wr_exp));
    endtask

    initial begin
        int w0;
        n_cmp = 0; n_err = 0; n_writes = 0;
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; xsum = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, BASE_ADDR);
        check("rst_imem_wd", imem_wd, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Nominal two-word load
        w0 = n_writes;
        expect_write(BASE_ADDR + 32'h0, 32'h00A0_0513);
        expect_write(BASE_ADDR + 32'h4, 32'h00B0_0593);
        send_hdr(32'd2);
        send_word(32'h00A0_0513, 0);
        send_word(32'h00B0_0593, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        check("nominal_xsum_model", 32'(xsum), 32'h90);
        send_byte(xsum);
`endif
        wait_end("nominal");
        @(posedge clk); #1;
        check_ok("nominal", w0, 2);

        // Bytes after done are refused and change nothing
        w0 = n_writes;
        byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            byte_data = 8'(8'h11 * i);
            @(posedge clk); #1;
            check("post_done_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        check("post_done_addr", imem_addr, BASE_ADDR + 32'h4);
        check("post_done_wd", imem_wd, 32'h00B0_0593);
        check_ok("post_done", w0, 0);

        // Stalled source: gaps inserted between bytes
        do_reset();
        w0 = n_writes;
        expect_write(BASE_ADDR + 32'h0, 32'h00A0_0513);
        expect_write(BASE_ADDR + 32'h4, 32'h00B0_0593);
        send_hdr(32'd2);
        send_word(32'h00A0_0513, 2);
        send_word(32'h00B0_0593, 2);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        idle(2);
        send_byte(xsum);
`endif
        wait_end("stalled");
        check_ok("stalled", w0, 2);

        // Header N = 0
        do_reset();
        w0 = n_writes;
        send_hdr(32'd0);
        wait_end("hdr_zero");
        idle(3);
        check_err("hdr_zero", w0, 0);
        check("hdr_zero_ready", 32'(byte_ready), 32'd0);

        // Header N = MEM_WORDS + 1
        do_reset();
        w0 = n_writes;
        send_hdr(32'(MEM_WORDS + 1));
        wait_end("hdr_big");
        idle(3);
        check_err("hdr_big", w0, 0);

        // Header N = MEM_WORDS is accepted and the loader waits for payload
        do_reset();
        send_hdr(32'(MEM_WORDS));
        idle(2);
        check("hdr_max_error", 32'(error), 32'd0);
        check("hdr_max_ready", 32'(byte_ready), 32'd1);
        check("hdr_max_core_rst", 32'(core_rst), 32'd1);

        // Reset mid-load after 6 payload bytes, then reload a 1-word image
        do_reset();
        w0 = n_writes;
        expect_write(BASE_ADDR + 32'h0, 32'h00A0_0513);
        send_hdr(32'd2);
        send_word(32'h00A0_0513, 0);
        send_byte(8'h93);
        send_byte(8'h05);
        #3 rst = 1'b1;
        #1;
        check("midrst_core_rst", 32'(core_rst), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_addr", imem_addr, BASE_ADDR);
        @(posedge clk); #1;
        rst = 1'b0;
        xsum = 8'h00;
        check("midrst_writes", 32'(n_writes - w0), 32'd1);
        w0 = n_writes;
        expect_write(BASE_ADDR, 32'hDEAD_BEEF);
        send_hdr(32'd1);
        send_word(32'hDEAD_BEEF, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        send_byte(xsum);
`endif
        wait_end("reload");
        check_ok("reload", w0, 1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        // Checksum mismatch: words stay written, image rejected
        do_reset();
        w0 = n_writes;
        expect_write(BASE_ADDR + 32'h0, 32'h00A0_0513);
        expect_write(BASE_ADDR + 32'h4, 32'h00B0_0593);
        send_hdr(32'd2);
        send_word(32'h00A0_0513, 0);
        send_word(32'h00B0_0593, 0);
        send_byte(8'h09);
        wait_end("csum_bad");
        check_err("csum_bad", w0, 2);
`endif

        idle(3);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover_expected: %0d writes never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
